// File: rtl/ps2_lcd_writer.sv
// ps2_lcd_writer: decodes PS/2 make codes to ASCII, queues them in a small FIFO,
// and types them onto an HD44780 in 8-bit mode with cursor and line-wrap tracking.
module ps2_lcd_writer #(
  parameter int EN_CYCLES = 16,
  parameter int CMD_WAIT  = 1200,
  parameter int CLR_WAIT  = 46000,
  parameter int PWR_WAIT  = 420000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_code,
  input  logic       ps2_code_new,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       char_drop
);
  localparam logic [2:0] PWR   = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] IDLE  = 3'd2;
  localparam logic [2:0] SETUP = 3'd3;
  localparam logic [2:0] EHIGH = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;

  // 0x00 marks an unmapped code; no mapped character is NUL
  function automatic logic [7:0] ascii_of(input logic [7:0] c);
    case (c)
      8'h1C: ascii_of = 8'h41;
      8'h32: ascii_of = 8'h42;
      8'h21: ascii_of = 8'h43;
      8'h23: ascii_of = 8'h44;
      8'h24: ascii_of = 8'h45;
      8'h2B: ascii_of = 8'h46;
      8'h34: ascii_of = 8'h47;
      8'h33: ascii_of = 8'h48;
      8'h43: ascii_of = 8'h49;
      8'h3B: ascii_of = 8'h4A;
      8'h42: ascii_of = 8'h4B;
      8'h4B: ascii_of = 8'h4C;
      8'h3A: ascii_of = 8'h4D;
      8'h31: ascii_of = 8'h4E;
      8'h44: ascii_of = 8'h4F;
      8'h4D: ascii_of = 8'h50;
      8'h15: ascii_of = 8'h51;
      8'h2D: ascii_of = 8'h52;
      8'h1B: ascii_of = 8'h53;
      8'h2C: ascii_of = 8'h54;
      8'h3C: ascii_of = 8'h55;
      8'h2A: ascii_of = 8'h56;
      8'h1D: ascii_of = 8'h57;
      8'h22: ascii_of = 8'h58;
      8'h35: ascii_of = 8'h59;
      8'h1A: ascii_of = 8'h5A;
      8'h45: ascii_of = 8'h30;
      8'h16: ascii_of = 8'h31;
      8'h1E: ascii_of = 8'h32;
      8'h26: ascii_of = 8'h33;
      8'h25: ascii_of = 8'h34;
      8'h2E: ascii_of = 8'h35;
      8'h36: ascii_of = 8'h36;
      8'h3D: ascii_of = 8'h37;
      8'h3E: ascii_of = 8'h38;
      8'h46: ascii_of = 8'h39;
      8'h29: ascii_of = 8'h20;
      8'h5A: ascii_of = 8'h0A;
      8'h66: ascii_of = 8'h08;
      default: ascii_of = 8'h00;
    endcase
  endfunction

  logic       brk_q, brk_d, ext_q, ext_d;
  logic       push, pop, wr, full, empty, drop_q;
  logic [7:0] tok, head;
  logic [7:0] fifo_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] fn_q;

  assign tok = ascii_of(ps2_code);

  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    push  = 1'b0;
    if (ps2_code_new) begin
      if (ps2_code == 8'hE0) ext_d = 1'b1;
      else if (ps2_code == 8'hF0) brk_d = 1'b1;
      else if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else push = tok != 8'h00;
    end
  end

  assign full  = fn_q == 3'd4;
  assign empty = fn_q == 3'd0;
  assign wr    = push && (!full || pop);
  assign head  = fifo_q[rp_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
      wp_q   <= 2'd0;
      rp_q   <= 2'd0;
      fn_q   <= 3'd0;
      drop_q <= 1'b0;
    end else begin
      brk_q  <= brk_d;
      ext_q  <= ext_d;
      wp_q   <= wp_q + 2'(wr);
      rp_q   <= rp_q + 2'(pop);
      fn_q   <= fn_q + 3'(wr) - 3'(pop);
      drop_q <= push && !wr;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) fifo_q[wp_q] <= tok;
  end

  // pend_q holds the remaining {rs, data} writes of the current sequence; entry 0 drives the bus
  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d, wait_lim;
  logic [8:0]  pend_q [4];
  logic [8:0]  pend_d [4];
  logic [2:0]  pn_q, pn_d;
  logic        line_q, line_d;
  logic [3:0]  col_q, col_d;
  logic [7:0]  other_addr, bs_addr;

  assign other_addr = {1'b1, ~line_q, 6'd0};
  assign bs_addr    = {1'b1, line_q, 2'b00, col_q - 4'd1};
  assign wait_lim   = (pend_q[0] == 9'h001) ? 32'(CLR_WAIT) : 32'(CMD_WAIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    pend_d  = pend_q;
    pn_d    = pn_q;
    line_d  = line_q;
    col_d   = col_q;
    pop     = 1'b0;
    case (state_q)
      PWR: begin
        if (cnt_q == 32'(PWR_WAIT - 1)) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      INIT: begin
        pend_d  = '{9'h038, 9'h00C, 9'h006, 9'h001};
        pn_d    = 3'd4;
        line_d  = 1'b0;
        col_d   = 4'd0;
        state_d = SETUP;
        cnt_d   = '0;
      end
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETUP;
          if (head == 8'h0A) begin
            pend_d[0] = {1'b0, other_addr};
            pn_d      = 3'd1;
            line_d    = ~line_q;
            col_d     = 4'd0;
          end else if (head == 8'h08) begin
            if (col_q == 4'd0) state_d = IDLE;
            else begin
              pend_d[0] = {1'b0, bs_addr};
              pend_d[1] = 9'h120;
              pend_d[2] = {1'b0, bs_addr};
              pn_d      = 3'd3;
              col_d     = col_q - 4'd1;
            end
          end else begin
            pend_d[0] = {1'b1, head};
            pend_d[1] = {1'b0, other_addr};
            pn_d      = (col_q == 4'd15) ? 3'd2 : 3'd1;
            line_d    = line_q ^ (col_q == 4'd15);
            col_d     = col_q + 4'd1;
          end
        end
      end
      SETUP: begin
        state_d = EHIGH;
        cnt_d   = '0;
      end
      EHIGH: begin
        if (cnt_q == 32'(EN_CYCLES - 1)) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == wait_lim - 32'd1) begin
          cnt_d   = '0;
          state_d = (pn_q > 3'd1) ? SETUP : IDLE;
          if (pn_q > 3'd1) begin
            pend_d[0] = pend_q[1];
            pend_d[1] = pend_q[2];
            pend_d[2] = pend_q[3];
            pn_d      = pn_q - 3'd1;
          end
        end
      end
      default: state_d = PWR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PWR;
      cnt_q   <= '0;
      pend_q  <= '{default: 9'h000};
      pn_q    <= 3'd0;
      line_q  <= 1'b0;
      col_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pn_q    <= pn_d;
      line_q  <= line_d;
      col_q   <= col_d;
    end
  end

  assign lcd_data  = pend_q[0][7:0];
  assign lcd_rs    = pend_q[0][8];
  assign lcd_rw    = 1'b0;
  assign lcd_e     = state_q == EHIGH;
  assign char_drop = drop_q;
endmodule

// File: tb/tb_ps2_lcd_writer.sv
// tb_ps2_lcd_writer: directed vector table plus hand-written sequences for the
// PS/2-to-LCD writer; a bus monitor logs every completed lcd_e write.
module tb_ps2_lcd_writer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_code_new = 1'b0;
  logic [7:0] ps2_code = 8'h00;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_e, char_drop;

  int total = 0, bad = 0, cyc = 0, nw = 0, ndrop = 0, elen = 0;
  logic       e_prev = 1'b0;
  logic       w_rs   [256];
  logic [7:0] w_data [256];
  logic       w_ok   [256];
  int         w_t    [256];
  int         w_len  [256];

  typedef struct {
    logic [7:0] c0, c1, c2;
    int         n;
    logic       v;
    logic [7:0] d;
  } vec_t;

  ps2_lcd_writer #(.EN_CYCLES(2), .CMD_WAIT(4), .CLR_WAIT(8), .PWR_WAIT(10)) dut (
    .clk(clk), .rst(rst), .ps2_code(ps2_code), .ps2_code_new(ps2_code_new),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .char_drop(char_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) e_prev = 1'b0;
    else begin
      if (char_drop) ndrop++;
      if (lcd_e && !e_prev) begin
        w_rs[nw] = lcd_rs;
        w_data[nw] = lcd_data;
        w_t[nw] = cyc;
        elen = 0;
      end
      if (lcd_e) elen++;
      if (!lcd_e && e_prev) begin
        w_len[nw] = elen;
        w_ok[nw] = (lcd_rs == w_rs[nw]) && (lcd_data == w_data[nw]);
        if (nw < 255) nw++;
      end
      e_prev = lcd_e;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] c);
    ps2_code = c;
    ps2_code_new = 1'b1;
    tick(1);
    ps2_code_new = 1'b0;
  endtask

  task automatic settle(input string name, input int base, input int n);
    for (int i = 0; i < 600 && nw < base + n; i++) tick(1);
    tick(24);
    chk(name, nw - base, n);
  endtask

  // packs {data stable at e fall, e width, rs, data} so one compare covers the whole write
  task automatic chk_w(input string name, input int i, input logic rs, input logic [7:0] d);
    chk(name, int'({w_ok[i], w_len[i][3:0], w_rs[i], w_data[i]}), int'({1'b1, 4'd2, rs, d}));
  endtask

  task automatic chk_init(input int base, input int r);
    logic [7:0] cmds [4];
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    chk("pwr_delay", w_t[base] - r, 12);
    for (int k = 0; k < 4; k++) chk_w($sformatf("init_cmd%0d", k), base + k, 1'b0, cmds[k]);
    for (int k = 0; k < 3; k++) chk($sformatf("init_gap%0d", k), w_t[base + k + 1] - w_t[base + k], 7);
  endtask

  initial begin
    vec_t tbl [14];
    logic [7:0] six [6];
    int base, r;
    tbl[0]  = '{8'h1C, 8'h00, 8'h00, 1, 1'b1, 8'h41};
    tbl[1]  = '{8'hF0, 8'h1C, 8'h00, 2, 1'b0, 8'h00};
    tbl[2]  = '{8'h14, 8'h00, 8'h00, 1, 1'b0, 8'h00};
    tbl[3]  = '{8'hE0, 8'h75, 8'h00, 2, 1'b0, 8'h00};
    tbl[4]  = '{8'h16, 8'h00, 8'h00, 1, 1'b1, 8'h31};
    tbl[5]  = '{8'hE0, 8'hF0, 8'h75, 3, 1'b0, 8'h00};
    tbl[6]  = '{8'h45, 8'h00, 8'h00, 1, 1'b1, 8'h30};
    tbl[7]  = '{8'h46, 8'h00, 8'h00, 1, 1'b1, 8'h39};
    tbl[8]  = '{8'h1A, 8'h00, 8'h00, 1, 1'b1, 8'h5A};
    tbl[9]  = '{8'h29, 8'h00, 8'h00, 1, 1'b1, 8'h20};
    tbl[10] = '{8'h76, 8'h00, 8'h00, 1, 1'b0, 8'h00};
    tbl[11] = '{8'hF0, 8'h29, 8'h00, 2, 1'b0, 8'h00};
    tbl[12] = '{8'h3B, 8'h00, 8'h00, 1, 1'b1, 8'h4A};
    tbl[13] = '{8'hE0, 8'h5A, 8'h00, 2, 1'b0, 8'h00};
    six = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    tick(3);
    chk("rst_data", int'(lcd_data), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_rw", int'(lcd_rw), 0);
    chk("rst_e", int'(lcd_e), 0);
    chk("rst_drop", int'(char_drop), 0);

    rst = 1'b0;
    r = cyc;
    base = nw;
    tick(2);
    for (int i = 0; i < 6; i++) strobe(six[i]);
    settle("init_count", base, 8);
    chk_init(base, r);
    for (int k = 0; k < 4; k++) chk_w($sformatf("queued%0d", k), base + 4 + k, 1'b1, 8'h41 + 8'(k));
    chk("clr_gap", w_t[base + 4] - w_t[base + 3], 12);
    chk("tok_gap", w_t[base + 5] - w_t[base + 4], 8);
    chk("drops_init", ndrop, 2);

    for (int i = 0; i < 14; i++) begin
      base = nw;
      strobe(tbl[i].c0);
      if (tbl[i].n > 1) strobe(tbl[i].c1);
      if (tbl[i].n > 2) strobe(tbl[i].c2);
      settle($sformatf("vec%0d_count", i), base, int'(tbl[i].v));
      if (tbl[i].v) chk_w($sformatf("vec%0d_write", i), base, 1'b1, tbl[i].d);
    end

    strobe(8'h29);
    tick(2);
    chk("pre_rst_e", int'(lcd_e), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_e", int'(lcd_e), 0);
    chk("async_rst_data", int'(lcd_data), 0);
    chk("async_rst_rs", int'(lcd_rs), 0);
    tick(2);
    rst = 1'b0;
    r = cyc;
    base = nw;
    settle("reinit_count", base, 4);
    chk_init(base, r);

    base = nw;
    for (int i = 0; i < 17; i++) begin
      strobe(8'h29);
      tick(20);
    end
    settle("wrap_count", base, 18);
    for (int i = 0; i < 16; i++) chk_w($sformatf("wrap_dat%0d", i), base + i, 1'b1, 8'h20);
    chk_w("wrap_cmd", base + 16, 1'b0, 8'hC0);
    chk_w("wrap_17th", base + 17, 1'b1, 8'h20);

    base = nw;
    strobe(8'h5A);
    settle("enter_count", base, 1);
    chk_w("enter_cmd", base, 1'b0, 8'h80);

    base = nw;
    strobe(8'h1C);
    strobe(8'h32);
    settle("ab_count", base, 2);
    chk_w("ab_a", base, 1'b1, 8'h41);
    chk_w("ab_b", base + 1, 1'b1, 8'h42);

    base = nw;
    strobe(8'h66);
    settle("bs1_count", base, 3);
    chk_w("bs1_cmd", base, 1'b0, 8'h81);
    chk_w("bs1_dat", base + 1, 1'b1, 8'h20);
    chk_w("bs1_cmd2", base + 2, 1'b0, 8'h81);

    base = nw;
    strobe(8'h66);
    settle("bs2_count", base, 3);
    chk_w("bs2_cmd", base, 1'b0, 8'h80);
    chk_w("bs2_dat", base + 1, 1'b1, 8'h20);
    chk_w("bs2_cmd2", base + 2, 1'b0, 8'h80);

    base = nw;
    strobe(8'h66);
    settle("bs_col0_count", base, 0);

    chk("drops_total", ndrop, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
